// File: rtl/keypad_entry_buffer_if.sv
// Keypad scanner input pair and the entry buffer outputs.
// The buffer is the slave. The scanner and any display or consumer logic use the master side.
interface keypad_entry_buffer_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4:0]          key_value;
    logic                key_ready;
    logic [4*DIGITS-1:0] entry_bcd;
    logic [2:0]          digit_count;
    logic [4*DIGITS-1:0] entry_value;
    logic                entry_valid;
    logic                key_event;
    logic                overflow;

    modport master (
        output key_value,
        output key_ready,
        input  entry_bcd,
        input  digit_count,
        input  entry_value,
        input  entry_valid,
        input  key_event,
        input  overflow
    );

    modport slave (
        input  key_value,
        input  key_ready,
        output entry_bcd,
        output digit_count,
        output entry_value,
        output entry_valid,
        output key_event,
        output overflow
    );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Debounces keypad presses, acts once per press, and accumulates BCD digits.
// Clear, backspace and enter are edit commands. Enter publishes the number with a one-cycle pulse.
module keypad_entry_buffer #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input logic                  clk,
    input logic                  rst,
    keypad_entry_buffer_if.slave kb
);
    localparam int unsigned CntW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CntW-1:0] HoldMax  = CntW'(HOLD_CYCLES);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [2:0]      DigMax   = 3'(DIGITS);

    typedef enum logic [1:0] {StIdle, StQualify, StAct, StRelease} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [4:0]          cand_q, cand_d;
    logic                rdy_meta_q, rdy_s_q;
    logic [4:0]          code_meta_q, code_s_q;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [2:0]          count_q, count_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic                valid_q, valid_d;
    logic                event_q, event_d;
    logic                ovf_q, ovf_d;
    logic [4*DIGITS-1:0] bcd_shl;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_meta_q  <= 1'b0;
            rdy_s_q     <= 1'b0;
            code_meta_q <= '0;
            code_s_q    <= '0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= '0;
            bcd_q       <= '0;
            count_q     <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            event_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rdy_meta_q  <= kb.key_ready;
            rdy_s_q     <= rdy_meta_q;
            code_meta_q <= kb.key_value;
            code_s_q    <= code_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            bcd_q       <= bcd_d;
            count_q     <= count_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            event_q     <= event_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        bcd_d   = bcd_q;
        count_d = count_q;
        value_d = value_q;
        valid_d = 1'b0;
        event_d = 1'b0;
        ovf_d   = 1'b0;
        bcd_shl = bcd_q << 4;
        bcd_shl[3:0] = cand_q[3:0];

        case (state_q)
            StIdle: begin
                if (rdy_s_q) begin
                    cand_d  = code_s_q;
                    cnt_d   = CntOne;
                    state_d = StQualify;
                end
            end
            StQualify: begin
                if (!rdy_s_q || (code_s_q != cand_q)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == HoldMax) begin
                    state_d = StAct;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StAct: begin
                event_d = 1'b1;
                cnt_d   = '0;
                state_d = StRelease;
                if (cand_q < 5'd10) begin
                    if (count_q < DigMax) begin
                        bcd_d   = bcd_shl;
                        count_d = count_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    case (cand_q)
                        5'd10: begin
                            bcd_d   = '0;
                            count_d = '0;
                        end
                        5'd11: begin
                            if (count_q != 3'd0) begin
                                bcd_d   = bcd_q >> 4;
                                count_d = count_q - 3'd1;
                            end
                        end
                        5'd12: begin
                            if (count_q != 3'd0) begin
                                value_d = bcd_q;
                                valid_d = 1'b1;
                                bcd_d   = '0;
                                count_d = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StRelease: begin
                // Any high sample restarts the release window; code changes are ignored here.
                if (rdy_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign kb.entry_bcd   = bcd_q;
    assign kb.digit_count = count_q;
    assign kb.entry_value = value_q;
    assign kb.entry_valid = valid_q;
    assign kb.key_event   = event_q;
    assign kb.overflow    = ovf_q;
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: directed vectors, hand-written corner sequences,
// and random presses checked against a press-level model of the entry buffer.
module tb_keypad_entry_buffer;
    localparam int unsigned D = 4;
    localparam int unsigned H = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_entry_buffer_if #(.DIGITS(D)) kif ();

    keypad_entry_buffer #(
        .DIGITS      (D),
        .HOLD_CYCLES (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kb  (kif)
    );

    int checks   = 0;
    int failures = 0;
    int n_ev     = 0;
    int n_val    = 0;
    int n_ovf    = 0;

    // Pulses are counted per cycle high, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (!rst) begin
            if (kif.key_event)   n_ev++;
            if (kif.entry_valid) n_val++;
            if (kif.overflow)    n_ovf++;
        end
    end

    typedef struct {
        int code;
        int hold;
        int bcd;
        int cnt;
        int val;
        int ev;
        int valid;
        int ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int code, int hold, int bcd, int cnt, int val, int ev,
                                int valid, int ovf);
        vec_t v;
        v.code = code; v.hold = hold; v.bcd = bcd; v.cnt = cnt;
        v.val = val; v.ev = ev; v.valid = valid; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " entry_bcd"},   int'(kif.entry_bcd), 0);
        check({tag, " digit_count"}, int'(kif.digit_count), 0);
        check({tag, " entry_value"}, int'(kif.entry_value), 0);
        check({tag, " entry_valid"}, int'(kif.entry_valid), 0);
        check({tag, " key_event"},   int'(kif.key_event), 0);
        check({tag, " overflow"},    int'(kif.overflow), 0);
    endtask

    // Holds code for hold cycles, optionally changing the code at chg_at, then releases.
    task automatic press(input int code, input int hold, input int rel, input int chg_at,
                         input int chg_code);
        @(negedge clk);
        kif.key_value = 5'(code);
        kif.key_ready = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (i == chg_at) kif.key_value = 5'(chg_code);
            @(negedge clk);
        end
        kif.key_ready = 1'b0;
        kif.key_value = 5'd16;
        repeat (rel) @(negedge clk);
    endtask

    // Counts edges from the first edge that samples key_ready high up to key_event.
    task automatic measure_latency(input string name);
        int n;
        int found;
        n = 0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (kif.key_event) found = 1;
        end
        check(name, (found != 0) ? n : -1, int'(H) + 4);
    endtask

    // Press-level model of the entry buffer; digits held oldest first.
    int unsigned mq[$];
    int          model_val;

    function automatic int model_bcd();
        int v;
        v = 0;
        foreach (mq[i]) v = v * 16 + int'(mq[i]);
        return v;
    endfunction

    task automatic model_press(input int code, output int ev, output int val, output int ov);
        ev = 1; val = 0; ov = 0;
        if (code < 10) begin
            if (mq.size() < D) mq.push_back(code);
            else ov = 1;
        end else if (code == 10) begin
            mq.delete();
        end else if (code == 11) begin
            if (mq.size() > 0) void'(mq.pop_back());
        end else if (code == 12) begin
            if (mq.size() > 0) begin
                model_val = model_bcd();
                val = 1;
                mq.delete();
            end
        end
    endtask

    initial begin
        int e0, v0, o0;
        int xe, xv, xo;
        int code, hold, chg_at, chg_code, r;
        string tag;

        rst = 1'b1;
        kif.key_ready = 1'b0;
        kif.key_value = 5'd16;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // First press: exact latency, then held to 20 cycles and released.
        kif.key_value = 5'd1;
        kif.key_ready = 1'b1;
        measure_latency("first press latency");
        repeat (12) @(negedge clk);
        kif.key_ready = 1'b0;
        kif.key_value = 5'd16;
        repeat (20) @(negedge clk);
        check("first press bcd", int'(kif.entry_bcd), 'h1);
        check("first press count", int'(kif.digit_count), 1);

        tbl.push_back(mk(2,  20,  'h12,   2, 0,    1, 0, 0));
        tbl.push_back(mk(3,  20,  'h123,  3, 0,    1, 0, 0));
        tbl.push_back(mk(5,  3,   'h123,  3, 0,    0, 0, 0));
        tbl.push_back(mk(10, 20,  'h0,    0, 0,    1, 0, 0));
        tbl.push_back(mk(7,  200, 'h7,    1, 0,    1, 0, 0));
        tbl.push_back(mk(10, 20,  'h0,    0, 0,    1, 0, 0));
        tbl.push_back(mk(9,  20,  'h9,    1, 0,    1, 0, 0));
        tbl.push_back(mk(8,  20,  'h98,   2, 0,    1, 0, 0));
        tbl.push_back(mk(7,  20,  'h987,  3, 0,    1, 0, 0));
        tbl.push_back(mk(6,  20,  'h9876, 4, 0,    1, 0, 0));
        tbl.push_back(mk(5,  20,  'h9876, 4, 0,    1, 0, 1));
        tbl.push_back(mk(11, 20,  'h987,  3, 0,    1, 0, 0));
        tbl.push_back(mk(10, 20,  'h0,    0, 0,    1, 0, 0));
        tbl.push_back(mk(4,  20,  'h4,    1, 0,    1, 0, 0));
        tbl.push_back(mk(2,  20,  'h42,   2, 0,    1, 0, 0));
        tbl.push_back(mk(12, 20,  'h0,    0, 'h42, 1, 1, 0));
        tbl.push_back(mk(12, 20,  'h0,    0, 'h42, 1, 0, 0));
        tbl.push_back(mk(1,  20,  'h1,    1, 'h42, 1, 0, 0));
        tbl.push_back(mk(2,  20,  'h12,   2, 'h42, 1, 0, 0));
        tbl.push_back(mk(3,  20,  'h123,  3, 'h42, 1, 0, 0));
        tbl.push_back(mk(13, 20,  'h123,  3, 'h42, 1, 0, 0));
        tbl.push_back(mk(14, 20,  'h123,  3, 'h42, 1, 0, 0));
        tbl.push_back(mk(16, 20,  'h123,  3, 'h42, 1, 0, 0));
        tbl.push_back(mk(10, 20,  'h0,    0, 'h42, 1, 0, 0));
        tbl.push_back(mk(11, 20,  'h0,    0, 'h42, 1, 0, 0));

        foreach (tbl[i]) begin
            e0 = n_ev; v0 = n_val; o0 = n_ovf;
            press(tbl[i].code, tbl[i].hold, 20, -1, 0);
            tag = $sformatf("row%0d key%0d", i, tbl[i].code);
            check({tag, " entry_bcd"},   int'(kif.entry_bcd), tbl[i].bcd);
            check({tag, " digit_count"}, int'(kif.digit_count), tbl[i].cnt);
            check({tag, " entry_value"}, int'(kif.entry_value), tbl[i].val);
            check({tag, " key_event n"}, n_ev - e0, tbl[i].ev);
            check({tag, " entry_valid n"}, n_val - v0, tbl[i].valid);
            check({tag, " overflow n"},  n_ovf - o0, tbl[i].ovf);
        end

        // Code change while held must not create a second event.
        e0 = n_ev;
        press(7, 40, 20, 15, 8);
        check("held change events", n_ev - e0, 1);
        check("held change bcd", int'(kif.entry_bcd), 'h7);

        // Reset while qualifying code 3, key still held afterwards.
        @(negedge clk);
        kif.key_value = 5'd3;
        kif.key_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("mid-qualify reset");
        @(negedge clk);
        rst = 1'b0;
        measure_latency("post-reset latency");
        repeat (10) @(negedge clk);
        kif.key_ready = 1'b0;
        kif.key_value = 5'd16;
        repeat (20) @(negedge clk);
        check("post-reset bcd", int'(kif.entry_bcd), 'h3);
        check("post-reset count", int'(kif.digit_count), 1);
        check("post-reset value", int'(kif.entry_value), 0);

        // Random presses against the model, starting from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        model_val = 0;
        for (int it = 0; it < 120; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      code = int'($urandom_range(0, 9));
            else if (r < 8) code = int'($urandom_range(10, 12));
            else            code = int'($urandom_range(13, 31));
            e0 = n_ev; v0 = n_val; o0 = n_ovf;
            if ($urandom_range(0, 5) == 0) begin
                press(code, int'($urandom_range(1, H)), 20, -1, 0);
                xe = 0; xv = 0; xo = 0;
            end else begin
                hold = int'($urandom_range(H + 5, H + 40));
                chg_at = (hold >= int'(H) + 15 && $urandom_range(0, 1) == 1) ? int'(H) + 10 : -1;
                chg_code = int'($urandom_range(0, 31));
                press(code, hold, int'($urandom_range(H + 8, 30)), chg_at, chg_code);
                model_press(code, xe, xv, xo);
            end
            tag = $sformatf("rand%0d key%0d", it, code);
            check({tag, " entry_bcd"},     int'(kif.entry_bcd), model_bcd());
            check({tag, " digit_count"},   int'(kif.digit_count), mq.size());
            check({tag, " entry_value"},   int'(kif.entry_value), model_val);
            check({tag, " key_event n"},   n_ev - e0, xe);
            check({tag, " entry_valid n"}, n_val - v0, xv);
            check({tag, " overflow n"},    n_ovf - o0, xo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
